// File: rtl/tt_mpu_pkg.sv
// Types and constants shared between the matrix unit and its load-queue
// return path: entry layout, pointer type and matrix opcode encodings.
package tt_mpu_pkg;

    localparam int LQ_DEPTH_LOG2 = 3;
    localparam int VLEN          = 256;
    localparam int VREG_W        = 5;

    typedef struct packed {
        logic              alloc;
        logic              done;
        logic              exc;
        logic [VREG_W-1:0] vd;
        logic [VLEN-1:0]   data;
    } lq_entry_t;

    // Index bits plus one wrap bit so full and empty are distinguishable.
    typedef logic [LQ_DEPTH_LOG2:0] lq_ptr_t;

    localparam logic [6:0] MPU_OPCODE      = 7'b0101011;
    localparam logic [2:0] MPU_F3_MLOAD    = 3'b000;
    localparam logic [2:0] MPU_F3_MSTORE   = 3'b001;
    localparam logic [2:0] MPU_F3_MMUL     = 3'b010;
    localparam logic [2:0] MPU_F3_MMOVE_VX = 3'b011;

endpackage

// File: rtl/tt_mvex_lq_retire.sv
// Load-queue return capture: allocates ids in program order, accepts
// out-of-order returns by id, and retires in order to the VRF writeback port.
module tt_mvex_lq_retire #(
    parameter int LQ_DEPTH_LOG2 = tt_mpu_pkg::LQ_DEPTH_LOG2,
    parameter int VLEN          = tt_mpu_pkg::VLEN,
    parameter int VREG_W        = tt_mpu_pkg::VREG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic                     i_alloc_vld,
    input  logic [VREG_W-1:0]        i_alloc_vd,
    output logic                     o_alloc_rdy,
    output logic [LQ_DEPTH_LOG2-1:0] o_alloc_id,
    input  logic                     i_mvex_lqvld,
    input  logic [VLEN-1:0]          i_mvex_lqdata,
    input  logic                     i_mvex_lqexc,
    input  logic [LQ_DEPTH_LOG2-1:0] i_mvex_lqid,
    output logic                     o_wb_vld,
    output logic [VREG_W-1:0]        o_wb_vd,
    output logic [VLEN-1:0]          o_wb_data,
    output logic                     o_wb_exc,
    input  logic                     i_wb_rdy,
    output logic [LQ_DEPTH_LOG2:0]   o_count,
    output logic                     o_proto_err
);
    import tt_mpu_pkg::*;

    localparam int DEPTH = 2 ** LQ_DEPTH_LOG2;

    lq_entry_t entry_reg [DEPTH];
    lq_ptr_t   head_reg;
    lq_ptr_t   tail_reg;
    logic      proto_err_reg;

    logic [LQ_DEPTH_LOG2-1:0] head_idx;
    logic [LQ_DEPTH_LOG2-1:0] tail_idx;
    logic      full;
    logic      empty;
    lq_entry_t head_entry;
    lq_entry_t ret_entry;
    logic      alloc_fire;
    logic      wb_fire;
    logic      ret_capture;
    logic      ret_dup;

    assign head_idx = head_reg[LQ_DEPTH_LOG2-1:0];
    assign tail_idx = tail_reg[LQ_DEPTH_LOG2-1:0];
    assign full  = (head_idx == tail_idx) && (head_reg[LQ_DEPTH_LOG2] != tail_reg[LQ_DEPTH_LOG2]);
    assign empty = (head_reg == tail_reg);

    assign head_entry = entry_reg[head_idx];
    assign ret_entry  = entry_reg[i_mvex_lqid];

    // Readiness looks only at current state, so a slot freed by a retire
    // becomes allocatable on the following cycle.
    assign o_alloc_rdy = !full;
    assign o_alloc_id  = tail_idx;
    assign o_count     = tail_reg - head_reg;
    assign o_proto_err = proto_err_reg;

    assign o_wb_vld  = !empty && head_entry.alloc && head_entry.done;
    assign o_wb_vd   = head_entry.vd;
    assign o_wb_exc  = head_entry.exc;
    assign o_wb_data = head_entry.exc ? '0 : head_entry.data;

    // A return targeting the slot being allocated this cycle sees alloc=0
    // and is dropped as stale.
    assign alloc_fire  = !i_flush && i_alloc_vld && !full;
    assign wb_fire     = !i_flush && o_wb_vld && i_wb_rdy;
    assign ret_capture = !i_flush && i_mvex_lqvld && ret_entry.alloc && !ret_entry.done;
    assign ret_dup     = !i_flush && i_mvex_lqvld && ret_entry.alloc && ret_entry.done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i] <= '0;
            end
        end else if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_reg[i].alloc <= 1'b0;
                entry_reg[i].done  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_fire && tail_idx == LQ_DEPTH_LOG2'(i)) begin
                    entry_reg[i].alloc <= 1'b1;
                    entry_reg[i].done  <= 1'b0;
                    entry_reg[i].vd    <= i_alloc_vd;
                end
                if (ret_capture && i_mvex_lqid == LQ_DEPTH_LOG2'(i)) begin
                    entry_reg[i].done <= 1'b1;
                    entry_reg[i].exc  <= i_mvex_lqexc;
                    entry_reg[i].data <= i_mvex_lqdata;
                end
                if (wb_fire && head_idx == LQ_DEPTH_LOG2'(i)) begin
                    entry_reg[i].alloc <= 1'b0;
                    entry_reg[i].done  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            proto_err_reg <= 1'b0;
        end else if (i_flush) begin
            head_reg <= '0;
            tail_reg <= '0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (wb_fire) begin
                head_reg <= head_reg + 1'b1;
            end
            if (ret_dup) begin
                proto_err_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tt_mvex_lq_retire.sv
// Directed bench for the load-queue retire block with an in-order
// scoreboard of allocations and a small per-id model of returns.
module tb_tt_mvex_lq_retire;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_flush;
    logic         i_alloc_vld;
    logic [4:0]   i_alloc_vd;
    logic         o_alloc_rdy;
    logic [2:0]   o_alloc_id;
    logic         i_mvex_lqvld;
    logic [255:0] i_mvex_lqdata;
    logic         i_mvex_lqexc;
    logic [2:0]   i_mvex_lqid;
    logic         o_wb_vld;
    logic [4:0]   o_wb_vd;
    logic [255:0] o_wb_data;
    logic         o_wb_exc;
    logic         i_wb_rdy;
    logic [3:0]   o_count;
    logic         o_proto_err;

    tt_mvex_lq_retire dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_alloc_vld(i_alloc_vld), .i_alloc_vd(i_alloc_vd),
        .o_alloc_rdy(o_alloc_rdy), .o_alloc_id(o_alloc_id),
        .i_mvex_lqvld(i_mvex_lqvld), .i_mvex_lqdata(i_mvex_lqdata),
        .i_mvex_lqexc(i_mvex_lqexc), .i_mvex_lqid(i_mvex_lqid),
        .o_wb_vld(o_wb_vld), .o_wb_vd(o_wb_vd), .o_wb_data(o_wb_data),
        .o_wb_exc(o_wb_exc), .i_wb_rdy(i_wb_rdy), .o_count(o_count),
        .o_proto_err(o_proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] id;
        logic [4:0] vd;
    } sb_item_t;
    sb_item_t sb [$];

    logic         m_alloc [8];
    logic         m_done  [8];
    logic         m_exc   [8];
    logic [255:0] m_data  [8];
    logic [3:0]   m_head;
    logic [3:0]   m_tail;
    logic         m_perr;

    logic [4:0]   snap_vd;
    logic [255:0] snap_data;
    logic         snap_exc;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_alloc[i] = 1'b0;
            m_done[i]  = 1'b0;
            m_exc[i]   = 1'b0;
            m_data[i]  = '0;
        end
        m_head = '0;
        m_tail = '0;
        m_perr = 1'b0;
        sb.delete();
    endtask

    // Inputs are already driven; check state before the edge, then advance
    // the model across the edge and return at posedge+1.
    task automatic tick();
        logic [2:0] h;
        logic       exp_full;
        logic       exp_vld;
        logic       cap;
        logic       dup;
        sb_item_t   it;
        @(negedge clk);
        h        = m_head[2:0];
        exp_full = (m_head[2:0] == m_tail[2:0]) && (m_head[3] != m_tail[3]);
        exp_vld  = m_alloc[h] && m_done[h];
        chk("alloc_rdy", o_alloc_rdy, !exp_full);
        chk("alloc_id", o_alloc_id, m_tail[2:0]);
        chk("count", o_count, m_tail - m_head);
        chk("wb_vld", o_wb_vld, exp_vld);
        chk("proto_err", o_proto_err, m_perr);
        if (exp_vld && i_wb_rdy && !i_flush) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                it = sb.pop_front();
                $display("retire id=%0d vd=%0d exc=%0b data=%0h", it.id, o_wb_vd, o_wb_exc, o_wb_data);
                chk("wb_vd", o_wb_vd, it.vd);
                chk("wb_exc", o_wb_exc, m_exc[it.id]);
                chk("wb_data", o_wb_data, m_exc[it.id] ? 256'd0 : m_data[it.id]);
            end
        end
        if (i_flush) begin
            for (int i = 0; i < 8; i++) begin
                m_alloc[i] = 1'b0;
                m_done[i]  = 1'b0;
            end
            m_head = '0;
            m_tail = '0;
            sb.delete();
        end else begin
            cap = i_mvex_lqvld && m_alloc[i_mvex_lqid] && !m_done[i_mvex_lqid];
            dup = i_mvex_lqvld && m_alloc[i_mvex_lqid] && m_done[i_mvex_lqid];
            if (cap) begin
                m_done[i_mvex_lqid] = 1'b1;
                m_exc[i_mvex_lqid]  = i_mvex_lqexc;
                m_data[i_mvex_lqid] = i_mvex_lqdata;
            end
            if (dup) m_perr = 1'b1;
            if (exp_vld && i_wb_rdy) begin
                m_alloc[h] = 1'b0;
                m_done[h]  = 1'b0;
                m_head     = m_head + 1'b1;
            end
            if (i_alloc_vld && !exp_full) begin
                m_alloc[m_tail[2:0]] = 1'b1;
                m_done[m_tail[2:0]]  = 1'b0;
                sb.push_back('{id: m_tail[2:0], vd: i_alloc_vd});
                $display("alloc id=%0d vd=%0d", m_tail[2:0], i_alloc_vd);
                m_tail = m_tail + 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ret(input logic [2:0] id, input logic [255:0] data, input logic exc);
        i_mvex_lqvld  = 1'b1;
        i_mvex_lqid   = id;
        i_mvex_lqdata = data;
        i_mvex_lqexc  = exc;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wb_vld"}, o_wb_vld, 1'b0);
        chk({tag, "_wb_data"}, o_wb_data, 256'd0);
        chk({tag, "_wb_vd"}, o_wb_vd, 5'd0);
        chk({tag, "_wb_exc"}, o_wb_exc, 1'b0);
        chk({tag, "_count"}, o_count, 4'd0);
        chk({tag, "_alloc_rdy"}, o_alloc_rdy, 1'b1);
        chk({tag, "_alloc_id"}, o_alloc_id, 3'd0);
        chk({tag, "_proto_err"}, o_proto_err, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        i_flush = 1'b0;
        i_alloc_vld = 1'b0;
        i_alloc_vd = '0;
        i_mvex_lqvld = 1'b0;
        i_mvex_lqdata = '0;
        i_mvex_lqexc = 1'b0;
        i_mvex_lqid = '0;
        i_wb_rdy = 1'b0;
        model_reset();
        #2;
        chk_reset_outputs("rst");
        #5 reset = 1'b0;
        @(posedge clk);
        #1;

        // Out-of-order returns, in-order retire.
        i_alloc_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_alloc_vd = 5'(3 + i);
            tick();
        end
        i_alloc_vld = 1'b0;
        i_wb_rdy = 1'b1;
        ret(3'd2, 256'hC, 1'b0); tick();
        ret(3'd0, 256'hA, 1'b0); tick();
        ret(3'd1, 256'hB, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("drain_count", o_count, 4'd0);

        // Fill across the wrap point; ninth request is held while full.
        i_wb_rdy = 1'b0;
        i_alloc_vld = 1'b1;
        for (int i = 0; i < 9; i++) begin
            i_alloc_vd = (i == 8) ? 5'd20 : 5'(8 + i);
            tick();
        end
        chk("full_rdy", o_alloc_rdy, 1'b0);
        chk("full_count", o_count, 4'd8);
        for (int i = 0; i < 8; i++) begin
            if (i == 0) ret(3'd3, 256'hFF, 1'b1);
            else ret(3'((3 + i) % 8), 256'h100 + 256'(i), 1'b0);
            tick();
        end
        i_mvex_lqvld = 1'b0;

        // Exception head held under backpressure.
        tick();
        chk("exc_flag", o_wb_exc, 1'b1);
        chk("exc_data_zero", o_wb_data, 256'd0);
        snap_vd = o_wb_vd;
        snap_data = o_wb_data;
        snap_exc = o_wb_exc;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_vld", o_wb_vld, 1'b1);
            chk("hold_vd", o_wb_vd, snap_vd);
            chk("hold_data", o_wb_data, snap_data);
            chk("hold_exc", o_wb_exc, snap_exc);
        end

        // Duplicate return: sticky error, data untouched.
        ret(3'd4, 256'hDEAD, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        chk("dup_err", o_proto_err, 1'b1);
        i_wb_rdy = 1'b1; tick();
        i_wb_rdy = 1'b0; tick();
        tick();
        i_alloc_vld = 1'b0;
        ret(3'd3, 256'h77, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        i_wb_rdy = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("dup_err_sticky", o_proto_err, 1'b1);

        // Asynchronous reset in the middle of traffic.
        i_wb_rdy = 1'b0;
        i_alloc_vld = 1'b1;
        i_alloc_vd = 5'd1; tick();
        i_alloc_vd = 5'd2; tick();
        i_alloc_vld = 1'b0;
        ret(3'd4, 256'h55, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        tick();
        chk("pre_rst_vld", o_wb_vld, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk_reset_outputs("async_rst");
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk);
        #1;

        // Flush colliding with a return and an alloc.
        i_alloc_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            i_alloc_vd = 5'(10 + i);
            tick();
        end
        i_alloc_vld = 1'b0;
        ret(3'd0, 256'h99, 1'b0); tick();
        i_flush = 1'b1;
        i_alloc_vld = 1'b1;
        i_alloc_vd = 5'd14;
        i_wb_rdy = 1'b1;
        ret(3'd1, 256'h98, 1'b0); tick();
        i_flush = 1'b0;
        i_alloc_vld = 1'b0;
        i_mvex_lqvld = 1'b0;
        tick();
        chk("flush_count", o_count, 4'd0);
        chk("flush_vld", o_wb_vld, 1'b0);
        chk("flush_id", o_alloc_id, 3'd0);
        ret(3'd2, 256'h33, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        tick();
        chk("stale_err", o_proto_err, 1'b0);
        chk("stale_vld", o_wb_vld, 1'b0);

        // Queue still functional after the flush.
        i_alloc_vld = 1'b1;
        i_alloc_vd = 5'd7; tick();
        i_alloc_vld = 1'b0;
        ret(3'd0, 256'h44, 1'b0); tick();
        i_mvex_lqvld = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("final_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
